fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
//
// PURPOSE
// Instruction fetch queue between instruction memory (fetch stage) and decode.
// Captures {instr, pc} each cycle the memory reports a hit and presents them in
// order to decode with a valid/ready handshake. Decouples fetch from decode
// stalls, drops everything on a redirect (flush), and back-pressures the PC
// stage when full.
//
// PARAMETERS
// DEPTH    4   entries; power of two, >= 2
// XLEN     32  instruction and PC width
// NOP      32'h0000_0013  instruction driven on instr_d_o when empty (addi x0,x0,0)
//
// PORTS
// clk_i          in   1     clock, rising edge
// reset_n_i      in   1     asynchronous active-low reset
// flush_i        in   1     redirect (taken branch/jump); discard all contents
// fetch_valid_i  in   1     fetch stage presents a request this cycle
// pc_f_i         in   XLEN  PC of the fetched instruction
// instr_f_i      in   XLEN  instruction word from instruction memory
// instr_hit_f_i  in   1     instruction memory hit; word on instr_f_i usable
// stall_f_o      out  1     PC stage must hold its PC (queue full)
// valid_d_o      out  1     head entry valid for decode
// ready_d_i      in   1     decode accepts head entry this cycle
// instr_d_o      out  XLEN  head instruction (NOP when empty)
// pc_d_o         out  XLEN  head PC (0 when empty)
// count_o        out  $clog2(DEPTH)+1  current occupancy
//
// BEHAVIOUR
// - Reset (reset_n_i low, async): rd/wr pointers 0, count_o 0, valid_d_o 0,
//   stall_f_o 0, instr_d_o NOP, pc_d_o 0. Reset mid-operation drops all entries.
// - Storage: DEPTH-entry circular buffer of {pc, instr}; pointers are
//   $clog2(DEPTH)+1 bits, extra MSB is the wrap bit. empty: ptrs equal;
//   full: low bits equal, MSBs differ. Pointers wrap DEPTH-1 -> 0 naturally.
// - enq = fetch_valid_i & instr_hit_f_i & ~full & ~flush_i. Miss (hit=0)
//   never enqueues; fetch holds PC itself, queue is unaffected.
// - deq = valid_d_o & ready_d_i & ~flush_i.
// - stall_f_o = full (combinational from state only; no dependence on
//   ready_d_i). No enqueue when full even if dequeue occurs same cycle.
// - Simultaneous enq & deq (not full, not empty): both pointers advance,
//   count unchanged.
// - Latency: entry enqueued at edge N is visible on valid_d_o/instr_d_o/pc_d_o
//   after edge N (no same-cycle bypass from instr_f_i to instr_d_o).
// - Outputs: valid_d_o = ~empty; instr_d_o/pc_d_o = head entry when valid,
//   else NOP/0. Head outputs stable while valid_d_o & ~ready_d_i.
// - flush_i (sync): at the edge, pointers reset to 0, count 0; overrides any
//   enq/deq that cycle. valid_d_o low the following cycle. Next enqueue
//   accepted from the cycle after flush.
// - count_o: 0..DEPTH, never exceeds DEPTH or underflows.
// - No FSM beyond pointer state; all state updates on clk_i rising edge.
//
// TESTING
// 1. Reset: assert reset_n_i=0 mid-stream -> valid_d_o=0, count_o=0,
//    instr_d_o=32'h00000013, pc_d_o=0, stall_f_o=0 immediately.
// 2. Fill: ready_d_i=0, enqueue pc 0x00,0x04,0x08,0x0C -> count_o=4,
//    stall_f_o=1; 5th (pc 0x10) not accepted; head stays pc 0x00.
// 3. Drain in order: ready_d_i=1 after fill -> pc_d_o 0x00,0x04,0x08,0x0C
//    on consecutive cycles, then valid_d_o=0, instr_d_o=NOP.
// 4. Streaming + wrap: fetch 10 sequential hits with ready_d_i=1 -> count_o
//    stays 1 after first, all 10 delivered in order across pointer wrap.
// 5. Miss: instr_hit_f_i=0 for 3 cycles with fetch_valid_i=1 -> count_o
//    unchanged, no entries; hit resumes -> enqueue continues with same pc.
// 6. Flush: queue holds 3 entries, flush_i=1 with enq and deq asserted ->
//    next cycle count_o=0, valid_d_o=0; enqueue pc 0x200 -> delivered next.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {pc, instr} pairs from instruction memory
// hits and hands them to decode in order with a valid/ready handshake.
module fetch_queue #(
    parameter int              DEPTH = 4,
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = 32'h0000_0013
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    input  logic                     fetch_valid_i,
    input  logic [XLEN-1:0]          pc_f_i,
    input  logic [XLEN-1:0]          instr_f_i,
    input  logic                     instr_hit_f_i,
    output logic                     stall_f_o,
    output logic                     valid_d_o,
    input  logic                     ready_d_i,
    output logic [XLEN-1:0]          instr_d_o,
    output logic [XLEN-1:0]          pc_d_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];

    logic empty;
    logic full;
    logic enq;
    logic deq;

    // The extra pointer MSB is a wrap bit that separates full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign enq = fetch_valid_i & instr_hit_f_i & ~full & ~flush_i;
    assign deq = valid_d_o & ready_d_i & ~flush_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: the head outputs are masked whenever the queue is empty.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            pc_mem[wr_ptr[AW-1:0]]    <= pc_f_i;
            instr_mem[wr_ptr[AW-1:0]] <= instr_f_i;
        end
    end

    assign stall_f_o = full;
    assign valid_d_o = ~empty;
    assign instr_d_o = empty ? NOP : instr_mem[rd_ptr[AW-1:0]];
    assign pc_d_o    = empty ? '0  : pc_mem[rd_ptr[AW-1:0]];
    assign count_o   = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model checked
// every cycle, directed scenarios pinned with literal expectations, then random traffic.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] pc_f;
    logic [31:0] instr_f;
    logic        hit;
    logic        stall;
    logic        valid_d;
    logic        ready_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .NOP(NOP)) dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .flush_i       (flush),
        .fetch_valid_i (fetch_valid),
        .pc_f_i        (pc_f),
        .instr_f_i     (instr_f),
        .instr_hit_f_i (hit),
        .stall_f_o     (stall),
        .valid_d_o     (valid_d),
        .ready_d_i     (ready_d),
        .instr_d_o     (instr_d),
        .pc_d_o        (pc_d),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t model_q[$];

    int checks = 0;
    int errors = 0;

    // Literal expectations posted by the stimulus process, consumed at the next negedge.
    int          pin_req  = 0;
    int          pin_seen = 0;
    string       pin_name;
    logic        exp_valid;
    logic [2:0]  exp_count;
    logic        exp_stall;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    function automatic logic [31:0] mkInstr(input logic [31:0] pc);
        return {pc[19:0], 12'h093};
    endfunction

    // Reference model: a plain FIFO of {pc, instr} updated from the rules of the queue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            bit is_full;
            bit do_enq;
            bit do_deq;
            is_full = (model_q.size() == DEPTH);
            do_enq  = fetch_valid && hit && !is_full;
            do_deq  = (model_q.size() > 0) && ready_d;
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) model_q.push_back('{pc: pc_f, instr: instr_f});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Single compare process: model check every cycle plus any pending literal pin.
    always @(negedge clk) begin
        int          n;
        logic [31:0] m_pc;
        logic [31:0] m_instr;
        n       = model_q.size();
        m_pc    = (n > 0) ? model_q[0].pc    : 32'h0;
        m_instr = (n > 0) ? model_q[0].instr : NOP;
        checkOutput("model_valid", {31'b0, valid_d}, {31'b0, (n > 0)});
        checkOutput("model_count", {29'b0, count}, n);
        checkOutput("model_stall", {31'b0, stall}, {31'b0, (n == DEPTH)});
        checkOutput("model_pc",    pc_d, m_pc);
        checkOutput("model_instr", instr_d, m_instr);
        if (pin_req != pin_seen) begin
            pin_seen = pin_req;
            checkOutput({pin_name, "_valid"}, {31'b0, valid_d}, {31'b0, exp_valid});
            checkOutput({pin_name, "_count"}, {29'b0, count}, {29'b0, exp_count});
            checkOutput({pin_name, "_stall"}, {31'b0, stall}, {31'b0, exp_stall});
            checkOutput({pin_name, "_pc"},    pc_d, exp_pc);
            checkOutput({pin_name, "_instr"}, instr_d, exp_instr);
        end
    end

    task automatic pinState(input string name, input logic v, input logic [2:0] cnt,
                            input logic st, input logic [31:0] pc, input logic [31:0] instr);
        pin_name  = name;
        exp_valid = v;
        exp_count = cnt;
        exp_stall = st;
        exp_pc    = pc;
        exp_instr = instr;
        pin_req++;
    endtask

    // Drive one cycle of inputs, then return just after the rising edge.
    task automatic applyStimulus(input logic fv, input logic h, input logic [31:0] pc,
                                 input logic rdy, input logic fl);
        fetch_valid = fv;
        hit         = h;
        pc_f        = pc;
        instr_f     = mkInstr(pc);
        ready_d     = rdy;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        hit         = 1'b0;
        pc_f        = '0;
        instr_f     = '0;
        ready_d     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pinState("reset_init", 1'b0, 3'd0, 1'b0, 32'h0, NOP);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Fill to full with decode stalled, then try a fifth entry.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 32'(i * 4), 1'b0, 1'b0);
        pinState("fill_full", 1'b1, 3'd4, 1'b1, 32'h0, mkInstr(32'h0));
        applyStimulus(1'b1, 1'b1, 32'h10, 1'b0, 1'b0);
        pinState("fill_reject", 1'b1, 3'd4, 1'b1, 32'h0, mkInstr(32'h0));

        // Drain in order.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pinState("drain_1", 1'b1, 3'd3, 1'b0, 32'h4, mkInstr(32'h4));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pinState("drain_2", 1'b1, 3'd2, 1'b0, 32'h8, mkInstr(32'h8));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pinState("drain_3", 1'b1, 3'd1, 1'b0, 32'hC, mkInstr(32'hC));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pinState("drain_empty", 1'b0, 3'd0, 1'b0, 32'h0, NOP);

        // Streaming across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
            if (i == 0) pinState("stream_first", 1'b1, 3'd1, 1'b0, 32'h100, mkInstr(32'h100));
            if (i == 9) pinState("stream_last", 1'b1, 3'd1, 1'b0, 32'h124, mkInstr(32'h124));
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pinState("stream_empty", 1'b0, 3'd0, 1'b0, 32'h0, NOP);

        // Misses leave the queue untouched; the same pc is enqueued once it hits.
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h304, 1'b0, 1'b0);
        pinState("miss_hold", 1'b1, 3'd1, 1'b0, 32'h300, mkInstr(32'h300));
        applyStimulus(1'b1, 1'b1, 32'h304, 1'b0, 1'b0);
        pinState("miss_resume", 1'b1, 3'd2, 1'b0, 32'h300, mkInstr(32'h300));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        pinState("miss_next", 1'b1, 3'd1, 1'b0, 32'h304, mkInstr(32'h304));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush overrides a simultaneous enqueue and dequeue.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
        pinState("flush_pre", 1'b1, 3'd3, 1'b0, 32'h400, mkInstr(32'h400));
        applyStimulus(1'b1, 1'b1, 32'h40C, 1'b1, 1'b1);
        pinState("flush_empty", 1'b0, 3'd0, 1'b0, 32'h0, NOP);
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        pinState("flush_refill", 1'b1, 3'd1, 1'b0, 32'h200, mkInstr(32'h200));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a stream.
        applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h504, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        pinState("reset_mid", 1'b0, 3'd0, 1'b0, 32'h0, NOP);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Random traffic against the model, with one reset pulse partway through.
        for (int i = 0; i < 400; i++) begin
            fetch_valid = ($urandom_range(0, 3) != 0);
            hit         = ($urandom_range(0, 3) != 0);
            pc_f        = $urandom & 32'hFFFF_FFFC;
            instr_f     = $urandom;
            ready_d     = $urandom_range(0, 1) == 1;
            flush       = ($urandom_range(0, 19) == 0);
            if (i == 200) rst_n = 1'b0;
            if (i == 202) rst_n = 1'b1;
            @(posedge clk);
            #1;
        end

        fetch_valid = 1'b0;
        flush       = 1'b0;
        repeat (2) @(posedge clk);
        #6;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
